// File: rtl/dense_weight_sched_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the dense-layer weight scheduler.
package dense_weight_sched_pkg;

  localparam int DW_DATA_N   = 8;
  localparam int DW_CHAR_NUM = 192;
  localparam int DW_HID_DIM  = 24;
  localparam int DW_ADDR_W   = 10;
  localparam int DW_TIMEOUT  = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Inner group count: one BRAM word carries per_word weights.
  function automatic int dense_groups(input int chars, input int per_word);
    return chars / per_word;
  endfunction

  localparam int DW_G = dense_groups(DW_CHAR_NUM, DW_DATA_N);

endpackage

// File: rtl/dense_addr_gen.sv
// c1/c2 counter pair mirroring the compute block's counters, plus the mode-dependent BRAM address.
module dense_addr_gen #(
  parameter int G       = 24,
  parameter int HID_DIM = 24,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  input  logic              mode,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] G_W  = ADDR_W'(G);
  localparam logic [ADDR_W-1:0] H_W  = ADDR_W'(HID_DIM);
  localparam logic [ADDR_W-1:0] G_M1 = ADDR_W'(G - 1);
  localparam logic [ADDR_W-1:0] H_M1 = ADDR_W'(HID_DIM - 1);

  logic [ADDR_W-1:0] c1;
  logic [ADDR_W-1:0] c2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1 <= '0;
      c2 <= '0;
    end else if (clr) begin
      c1 <= '0;
      c2 <= '0;
    end else if (adv) begin
      if (c1 == G_M1) begin
        c1 <= '0;
        c2 <= c2 + 1'b1;
      end else begin
        c1 <= c1 + 1'b1;
      end
    end
  end

  assign last = (c1 == G_M1) && (c2 == H_M1);

  // Backward walks rows (row-major), forward walks columns (stride HID_DIM).
  assign addr = mode ? (c2 * G_W + c1) : (c1 * H_W + c2);

endmodule

// File: rtl/dense_weight_sched.sv
// Shares one weight-BRAM read port between the forward and backward dense blocks:
// runs the selected block, streams aligned read addresses, then reports done or a timeout error.
module dense_weight_sched
  import dense_weight_sched_pkg::*;
#(
  parameter int DENSE_DATA_N = DW_DATA_N,
  parameter int CHAR_NUM     = DW_CHAR_NUM,
  parameter int HID_DIM      = DW_HID_DIM,
  parameter int ADDR_W       = DW_ADDR_W,
  parameter int TIMEOUT      = DW_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic              fwd_valid,
  input  logic              bwd_valid,
  output logic              fwd_run,
  output logic              bwd_run,
  output logic              ren,
  output logic [ADDR_W-1:0] raddr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int G  = dense_groups(CHAR_NUM, DENSE_DATA_N);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t            state;
  logic              mode_r;
  logic [TW-1:0]     tcnt;
  logic              active;
  logic              sel_valid;
  logic              last;
  logic              cnt_clr;
  logic              cnt_adv;
  logic [ADDR_W-1:0] addr;

  assign active    = (state == ST_RUN) || (state == ST_WAIT);
  assign sel_valid = mode_r ? bwd_valid : fwd_valid;
  // Counters freeze on the final pair so WAIT keeps presenting the last address.
  assign cnt_adv   = (state == ST_RUN) && !last && !abort;
  assign cnt_clr   = abort || !active;

  dense_addr_gen #(
    .G       (G),
    .HID_DIM (HID_DIM),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .adv  (cnt_adv),
    .mode (mode_r),
    .last (last),
    .addr (addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mode_r <= 1'b0;
      tcnt   <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
      tcnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tcnt <= '0;
          if (start) begin
            mode_r <= mode;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (last) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sel_valid)           state <= ST_DONE;
          else if (tcnt == T_LAST) state <= ST_IDLE;
          else                     tcnt  <= tcnt + 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fwd_run = active && !mode_r;
  assign bwd_run = active && mode_r;
  assign ren     = active;
  assign raddr   = active ? addr : '0;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE) && !abort;
  assign err     = (state == ST_WAIT) && (tcnt == T_LAST) && !sel_valid && !abort;

endmodule

// File: tb/tb_dense_weight_sched.sv
// Randomized scoreboard bench for dense_weight_sched: per-cycle expected outputs queued at job accept.
module tb_dense_weight_sched;

  localparam int G  = 24;
  localparam int H  = 24;
  localparam int N  = G * H;
  localparam int TO = 64;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic abort = 1'b0;
  logic fwd_valid = 1'b0;
  logic bwd_valid = 1'b0;
  logic fwd_run, bwd_run, ren, busy, done, err;
  logic [AW-1:0] raddr;

  typedef struct packed {
    logic          busy;
    logic          ren;
    logic [AW-1:0] addr;
    logic          fr;
    logic          br;
    logic          dn;
    logic          er;
  } obs_t;

  obs_t sb[$];
  obs_t act_o, exp_o;
  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] rdata;
  logic          prev_ren = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always #5 clk = ~clk;

  dense_weight_sched #(
    .DENSE_DATA_N(8),
    .CHAR_NUM    (G * 8),
    .HID_DIM     (H),
    .ADDR_W      (AW),
    .TIMEOUT     (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .abort    (abort),
    .fwd_valid(fwd_valid),
    .bwd_valid(bwd_valid),
    .fwd_run  (fwd_run),
    .bwd_run  (bwd_run),
    .ren      (ren),
    .raddr    (raddr),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Registered-read BRAM model, word k holds k.
  always @(posedge clk) if (ren) rdata <= mem[raddr];

  // k-th weight fetched by a job: backward is linear, forward transposes the G x H grid.
  function automatic logic [AW-1:0] ref_addr(input bit m, input int k);
    if (m) return AW'(k);
    return AW'((k % G) * H + k / G);
  endfunction

  function automatic obs_t item(input bit m, input logic [AW-1:0] a, input bit dn, input bit er);
    obs_t o;
    o = '0;
    o.busy = 1'b1;
    if (dn) begin
      o.dn = 1'b1;
    end else begin
      o.ren  = 1'b1;
      o.addr = a;
      o.fr   = !m;
      o.br   = m;
      o.er   = er;
    end
    return o;
  endfunction

  task automatic expect_job(input bit m, input int n_reads, input int n_hold, input bit ends_done);
    for (int k = 0; k < n_reads; k++) sb.push_back(item(m, ref_addr(m, k), 1'b0, 1'b0));
    for (int h = 0; h < n_hold; h++)
      sb.push_back(item(m, ref_addr(m, N - 1), 1'b0, !ends_done && (h == n_hold - 1)));
    if (ends_done) sb.push_back(item(m, '0, 1'b1, 1'b0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // cut_kind: 0 none, 1 abort at RUN cycle cut_at, 2 async reset at RUN cycle cut_at. wait_d < 0: timeout.
  task automatic run_job(input bit m, input int wait_d, input int cut_kind, input int cut_at, input bit hold);
    int n_run;
    int n_wait;
    start = 1'b1;
    mode  = m;
    step();
    if (cut_kind == 1)      expect_job(m, cut_at + 1, 0, 1'b0);
    else if (cut_kind == 2) expect_job(m, cut_at, 0, 1'b0);
    else if (wait_d < 0)    expect_job(m, N, TO, 1'b0);
    else                    expect_job(m, N, wait_d + 1, 1'b1);
    n_run = (cut_kind != 0) ? cut_at : N;
    for (int i = 0; i < n_run; i++) begin
      start     = hold ? 1'b1 : 1'($urandom_range(0, 1));
      mode      = 1'($urandom_range(0, 1));
      fwd_valid = 1'($urandom_range(0, 1));
      bwd_valid = 1'($urandom_range(0, 1));
      step();
    end
    if (cut_kind == 1) begin
      start = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
    end else if (cut_kind == 2) begin
      start = 1'b0;
      fwd_valid = 1'b0;
      bwd_valid = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
    end else begin
      n_wait = (wait_d < 0) ? TO : wait_d + 1;
      for (int w = 0; w < n_wait; w++) begin
        start = hold ? 1'b1 : 1'($urandom_range(0, 1));
        mode  = 1'($urandom_range(0, 1));
        if (m) begin
          bwd_valid = (w == wait_d);
          fwd_valid = 1'($urandom_range(0, 1));
        end else begin
          fwd_valid = (w == wait_d);
          bwd_valid = 1'($urandom_range(0, 1));
        end
        step();
      end
      if (wait_d >= 0) begin
        start     = hold;
        fwd_valid = 1'($urandom_range(0, 1));
        bwd_valid = 1'($urandom_range(0, 1));
        step();
      end
    end
    if (!hold) start = 1'b0;
    fwd_valid = 1'b0;
    bwd_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    act_o = {busy, ren, raddr, fwd_run, bwd_run, done, err};
    exp_o = '0;
    if (sb.size() > 0) exp_o = sb.pop_front();
    vectors++;
    if (act_o !== exp_o) begin
      miscompares++;
      $display("FAIL outputs t=%0t got busy=%b ren=%b raddr=%0d fwd_run=%b bwd_run=%b done=%b err=%b want busy=%b ren=%b raddr=%0d fwd_run=%b bwd_run=%b done=%b err=%b",
               $time, act_o.busy, act_o.ren, act_o.addr, act_o.fr, act_o.br, act_o.dn, act_o.er,
               exp_o.busy, exp_o.ren, exp_o.addr, exp_o.fr, exp_o.br, exp_o.dn, exp_o.er);
    end
    if (prev_ren) begin
      vectors++;
      if (rdata !== prev_addr) begin
        miscompares++;
        $display("FAIL rdata t=%0t got %0d want %0d", $time, rdata, prev_addr);
      end
    end
    prev_ren  = exp_o.ren && rst_n;
    prev_addr = exp_o.addr;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < (1 << AW); k++) mem[k] = AW'(k);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();

    run_job(1'b1, 5, 0, 0, 1'b0);
    repeat (3) step();
    run_job(1'b0, 0, 0, 0, 1'b0);
    run_job(1'b1, -1, 0, 0, 1'b0);
    repeat (2) step();
    run_job(1'b0, TO - 1, 0, 0, 1'b0);
    run_job(1'b1, 2, 1, 30, 1'b0);
    run_job(1'b1, 7, 0, 0, 1'b0);
    run_job(1'b0, 3, 2, 10, 1'b0);
    repeat (2) step();
    run_job(1'b0, 1, 0, 0, 1'b0);

    for (int j = 0; j < 3; j++) run_job(1'($urandom_range(0, 1)), $urandom_range(0, 10), 0, 0, 1'b1);
    start = 1'b0;
    step();
    for (int j = 0; j < 3; j++) begin
      run_job(1'($urandom_range(0, 1)), $urandom_range(0, TO - 1), 0, 0, 1'b0);
      repeat ($urandom_range(0, 3)) step();
    end
    repeat (5) step();

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
